// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard FSM issuing load-use stalls, multiply/divide holds and branch redirects.
// Optional HAZARD_PERF_EN adds stall/redirect performance counters.
module hazard_ctrl #(
    parameter int MDU_CYCLES = 4,
    parameter int REG_W      = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken,
    input  logic [0:31]      br_target,
    input  logic             mdu_start,
    output logic             stall,
    output logic             pc_pulse,
    output logic [0:31]      pc_in,
    output logic             flush_id,
    output logic             hold_ex
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, LD_STALL, MDU_BUSY, REDIRECT} state_t;

    state_t     state, nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       hazard;

    assign hazard = ex_load && ex_rd != '0 &&
                    ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            RUN: begin
                if (br_taken)
                    nxt = REDIRECT;
                else if (mdu_start) begin
                    nxt     = MDU_BUSY;
                    cnt_nxt = 4'(MDU_CYCLES - 1);
                end else if (hazard)
                    nxt = LD_STALL;
            end
            MDU_BUSY: begin
                nxt     = cnt == 4'd0 ? RUN : MDU_BUSY;
                cnt_nxt = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
            end
            default: nxt = RUN;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= 4'd0;
            stall    <= 1'b0;
            hold_ex  <= 1'b0;
            pc_pulse <= 1'b0;
            flush_id <= 1'b0;
            pc_in    <= '0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            stall    <= nxt == LD_STALL || nxt == MDU_BUSY;
            hold_ex  <= nxt == MDU_BUSY;
            pc_pulse <= nxt == REDIRECT;
            flush_id <= nxt == REDIRECT;
            if (nxt == REDIRECT)
                pc_in <= br_target;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + 32'(stall);
            perf_flush_cnt <= perf_flush_cnt + 32'(pc_pulse);
        end
    end
`endif
endmodule
